// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative RV32M multiply/divide unit with a register-file write port.
// Revision : 1.0
// ============================================================================
module mdu_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [4:0]  dst,
    input  logic        flush,
    output logic        busy,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [5:0]  r_cnt;
    logic [31:0] r_opnd;     // multiplicand for MUL*, divisor for DIV*/REM*
    logic [31:0] r_hi;       // product high half / partial remainder
    logic [31:0] r_lo;       // multiplier bits / dividend bits, becomes product low / quotient
    logic        r_neg_res;
    logic        r_neg_rem;

    logic        w_accept;
    logic        w_s0;
    logic        w_s1;
    logic        w_neg0;
    logic        w_neg1;
    logic [31:0] w_mag0;
    logic [31:0] w_mag1;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_spec_res;

    always_comb begin
        w_accept   = (r_state == S_IDLE) && start && !flush;
        w_s0       = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
        w_s1       = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        w_neg0     = w_s0 && src0[31];
        w_neg1     = w_s1 && src1[31];
        w_mag0     = w_neg0 ? (32'd0 - src0) : src0;
        w_mag1     = w_neg1 ? (32'd0 - src1) : src1;
        w_div0     = op[2] && (src1 == 32'd0);
        w_ovf      = op[2] && !op[0] && (src0 == 32'h8000_0000) && (src1 == 32'hFFFF_FFFF);
        w_special  = w_div0 || w_ovf;
        if (w_div0) begin
            w_spec_res = op[1] ? src0 : 32'hFFFF_FFFF;
        end else begin
            w_spec_res = op[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    logic [32:0] w_madd;
    logic [32:0] w_shift;
    logic [33:0] w_dsub;
    logic        w_ge;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [63:0] w_raw;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_result;

    // One iteration step; the final step also feeds sign correction and result select.
    always_comb begin
        w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
        w_shift = {r_hi, r_lo[31]};
        w_dsub  = {1'b0, w_shift} - {2'b00, r_opnd};
        w_ge    = !w_dsub[33];
        if (r_op[2]) begin
            w_hi_nxt = w_ge ? w_dsub[31:0] : w_shift[31:0];
            w_lo_nxt = {r_lo[30:0], w_ge};
        end else begin
            w_hi_nxt = w_madd[32:1];
            w_lo_nxt = {w_madd[0], r_lo[31:1]};
        end
        w_raw  = {w_hi_nxt, w_lo_nxt};
        w_prod = r_neg_res ? (64'd0 - w_raw) : w_raw;
        w_quo  = r_neg_res ? (32'd0 - w_lo_nxt) : w_lo_nxt;
        w_rem  = r_neg_rem ? (32'd0 - w_hi_nxt) : w_hi_nxt;
        case (r_op)
            3'b000:                 w_result = w_prod[31:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[63:32];
            3'b100, 3'b101:         w_result = w_quo;
            default:                w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == 6'd31) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op      <= 3'd0;
            r_cnt     <= 6'd0;
            r_opnd    <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            rf_wa     <= 5'd0;
            rf_wd     <= 32'd0;
        end else if (w_accept) begin
            r_op      <= op;
            r_cnt     <= 6'd0;
            r_opnd    <= op[2] ? w_mag1 : w_mag0;
            r_hi      <= 32'd0;
            r_lo      <= op[2] ? w_mag0 : w_mag1;
            r_neg_res <= w_neg0 ^ w_neg1;
            r_neg_rem <= w_neg0;
            rf_wa     <= dst;
            if (w_special) begin
                rf_wd <= w_spec_res;
            end
        end else if (r_state == S_CALC) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 6'd1;
            if ((r_cnt == 6'd31) && !flush) begin
                rf_wd <= w_result;
            end
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign rf_we = (r_state == S_DONE) && (rf_wa != 5'd0) && !flush;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// Scoreboard bench for mdu_iter: a driver issues ops and queues expected writes,
// a monitor matches every rf_we strobe against the queue.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src0 = 32'd0;
    logic [31:0] src1 = 32'd0;
    logic [4:0]  dst = 5'd0;
    logic        busy;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    mdu_iter dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .src0  (src0),
        .src1  (src1),
        .dst   (dst),
        .flush (flush),
        .busy  (busy),
        .rf_we (rf_we),
        .rf_wa (rf_wa),
        .rf_wd (rf_wd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, required %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics from plain wide arithmetic. Returns {special, result}.
    function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint p;
        int     q;
        int     r;
        if (!o[2]) begin
            x = (o != 3'b011) ? longint'($signed(a)) : longint'(a);
            y = (o == 3'b000 || o == 3'b001) ? longint'($signed(b)) : longint'(b);
            p = x * y;
            return {1'b0, (o == 3'b000) ? p[31:0] : p[63:32]};
        end
        if (b == 32'd0) return {1'b1, o[1] ? a : 32'hFFFF_FFFF};
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, o[1] ? 32'h0000_0000 : 32'h8000_0000};
        if (!o[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = int'(a / b);
            r = int'(a % b);
        end
        return {1'b0, o[1] ? 32'(r) : 32'(q)};
    endfunction

    // Monitor: every write strobe must match the oldest expectation, in the right cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && rf_we) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got wa=%0d wd=%08h at cycle %0d, required no write",
                         rf_wa, rf_wd, cyc);
            end else begin
                e = sb.pop_front();
                check("wb_addr", 32'(rf_wa), 32'(e.wa));
                check("wb_data", rf_wd, e.wd);
                check("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Entered and left just after a rising edge. flush_at: cycle of a flush pulse
    // (0 = together with start, -1 = none); pulse_at: cycle of a stray start (-1 = none).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int flush_at, input int pulse_at);
        logic [32:0] m;
        int          lat;
        exp_t        e;
        m   = model(o, a, b);
        lat = m[32] ? 1 : 33;
        check("busy_at_accept", 32'(busy), 32'd0);
        op = o; src0 = a; src1 = b; dst = d; start = 1'b1;
        flush = (flush_at == 0);
        if (flush_at < 0 && d != 5'd0) begin
            e.wa = d; e.wd = m[31:0]; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        op = 3'($urandom); src0 = $urandom; src1 = $urandom; dst = 5'($urandom);
        for (int n = 1; n <= lat; n++) begin
            if (n == flush_at) flush = 1'b1;
            if (n == pulse_at) begin
                start = 1'b1; op = 3'b100; src1 = 32'd0; dst = 5'd1;
            end
            @(negedge clk);
            check("busy_active", 32'(busy), 32'((flush_at < 0) || (n <= flush_at)));
            @(posedge clk); #1;
            flush = 1'b0; start = 1'b0;
        end
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_we", 32'(rf_we), 32'd0);
        check("reset_wa", 32'(rf_wa), 32'd0);
        check("reset_wd", rf_wd, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed multiply/divide cases, issued back-to-back.
        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  -1, -1);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  -1, -1);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  -1, -1);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  -1, -1);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  -1, -1);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, -1, -1);
        run_op(3'b101, 32'd100,        32'd7,         5'd11, -1, -1);
        run_op(3'b111, 32'd100,        32'd7,         5'd12, -1, -1);
        // Special cases.
        run_op(3'b100, 32'd5,          32'd0,         5'd13, -1, -1);
        run_op(3'b111, 32'd5,          32'd0,         5'd14, -1, -1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, -1, -1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, -1, -1);
        // Handshake and suppression.
        run_op(3'b000, 32'd1234,       32'd5678,      5'd17, -1, 10);
        run_op(3'b001, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0,  -1, -1);
        run_op(3'b101, 32'd1000,       32'd3,         5'd18, 10, -1);
        run_op(3'b000, 32'd9,          32'd9,         5'd19, 0,  -1);
        run_op(3'b011, 32'hCAFE_F00D, 32'h0BAD_F00D, 5'd20, 33, -1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  d;
            int          sel;
            o   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) a = 32'($urandom_range(0, 255));
            d = (sel == 4) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(o, a, b, d, -1, (sel == 5) ? int'($urandom_range(2, 30)) : -1);
        end

        // Asynchronous reset in the middle of a DIVU.
        op = 3'b101; src0 = 32'd1000; src1 = 32'd7; dst = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_we", 32'(rf_we), 32'd0);
        check("midreset_wa", 32'(rf_wa), 32'd0);
        check("midreset_wd", rf_wd, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("postreset_busy", 32'(busy), 32'd0);
        run_op(3'b000, 32'd3, 32'd4, 5'd9, -1, -1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit sitting directly upstream of the register file's write port. It accepts one M-extension operation from the execute stage, computes it over 32 cycles (shift-add multiply, restoring divide), and delivers the result as a single-cycle register-file write (`rf_we` / `rf_wa` / `rf_wd`). The core stalls on `busy`; `flush` kills an in-flight operation on a redirect.

## Interface
- No parameters. Data width is fixed at 32 and the iteration count at 32.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE with `flush`=0.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src0`  in  32  rs1 value (multiplicand / dividend).
- `src1`  in  32  rs2 value (multiplier / divisor).
- `dst`  in  5  destination register index.
- `flush`  in  1  abort the current operation; no write-back.
- `busy`  out  1  high from the cycle after acceptance through the write-back cycle.
- `rf_we`  out  1  one-cycle write strobe to the register file.
- `rf_wa`  out  5  write address (latched `dst`).
- `rf_wd`  out  32  write data.

## Operation
- States:
  - IDLE → CALC on accepted `start`.
  - IDLE → DONE on accepted `start` when a special case applies.
  - CALC → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
  - `flush` in any state → IDLE.
- On acceptance, latch `op`, `dst`, operand magnitudes and result-sign flags, and clear a 6-bit iteration counter.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats `src0` as signed and `src1` as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
- Multiply: unsigned 32×32 shift-add into a 64-bit accumulator, one multiplier bit per cycle. Negate the 64-bit product if the operand signs differ. MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: unsigned restoring division, one quotient bit per cycle, with a 33-bit partial-remainder subtract.
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases resolve with no CALC cycles:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `src0`.
  - Signed overflow (`src0`=0x80000000, `src1`=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- The final sign correction and result select are registered into `rf_wd` on the CALC→DONE edge.
- `rf_we` = (state==DONE) & (`rf_wa`≠0) & ~`flush`. Writes to x0 are suppressed, but the unit still runs the full latency.
- `start` while `busy` is ignored; no queueing.
- `start` and `flush` in the same cycle: `flush` wins and the request is dropped.

## Timing
- Reset (`rstn`=0, asynchronous): state IDLE, counter 0, `busy`=0, `rf_we`=0, `rf_wa`=0, `rf_wd`=0. Reset mid-operation discards all work; no write follows.
- Normal op, with `start` sampled at the end of cycle 0:
  - Cycles 1–32: CALC.
  - Cycle 33: DONE, with `rf_we`/`rf_wa`/`rf_wd` valid.
  - Cycle 34: IDLE, `busy`=0, and a new `start` is accepted.
- Special case: cycle 1 is DONE; `busy`=0 in cycle 2.
- Throughput: one op per 34 cycles, back-to-back.
- `busy` is registered; it is 0 in the acceptance cycle itself.
- `flush` in CALC: `busy`=0 the next cycle and no write-back.
- `flush` during DONE: `rf_we` is masked combinationally in that cycle.
- `rf_wa` and `rf_wd` hold their last values in IDLE. Consumers qualify them with `rf_we` only.

## Test plan
- Multiply:
  - MUL 7 × 0xFFFFFFFD (−3), `dst`=5 → cycle 33: `rf_we`=1, `rf_wa`=5, `rf_wd`=0xFFFFFFEB; `busy` high for cycles 1–33.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases, each with write-back in cycle 1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Handshake:
  - `start` pulsed in cycle 10 of an active op → ignored; exactly one `rf_we`.
  - Second `start` in cycle 34 → accepted, result in cycle 67.
- Suppression:
  - `dst`=0 → `rf_we` never asserts and `busy` falls at cycle 34.
  - `flush` in cycle 10 → `busy`=0 in cycle 11, no `rf_we`.
  - `start`+`flush` together → nothing accepted.
- Reset:
  - `rstn` low in cycle 20 of a DIVU → outputs 0 immediately and no write-back.
  - After release, a fresh MUL 3 × 4 → `rf_wd`=12 at cycle 33.
